// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access-size enums, FSM
// states and the byte-enable mask for the 64-bit (two word) store lane.
package lsu_pkg;

  typedef enum logic [2:0] {
    NB_B  = 3'd0,
    NB_BU = 3'd1,
    NB_H  = 3'd2,
    NB_HU = 3'd3,
    NB_W  = 3'd4
  } num_byte_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_RESP  = 3'd3,
    S_WR_HI = 3'd4
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } acc_size_e;

  // num_byte 5..7 falls through to word size; stores reject those codes separately.
  function automatic acc_size_e size_of(input logic [2:0] nb);
    if (nb <= 3'd1) return SZ_B;
    else if (nb <= 3'd3) return SZ_H;
    else return SZ_W;
  endfunction

  function automatic logic [7:0] lane_be(input acc_size_e sz, input logic [1:0] off);
    logic [7:0] base;
    case (sz)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

  function automatic logic crosses(input acc_size_e sz, input logic [1:0] off);
    return ((sz == SZ_H) && (off == 2'd3)) || ((sz == SZ_W) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/lsu_misalign_unit_if.sv
// Core-side bus of the load/store unit: decoder controls in, load result,
// stall and error out, plus the FSM state for observation.
interface lsu_misalign_unit_if #(
  parameter int ADDR_W = 32
);
  import lsu_pkg::*;

  // The core holds a request (mem_read or mem_wren with addr/num_byte/st_data)
  // stable while stall is high; the request is consumed in the first cycle
  // stall is low. ld_valid is a one-cycle pulse qualifying ld_data, and err is
  // a one-cycle pulse flagging an illegal request.
  logic              mem_read;
  logic              mem_wren;
  logic [2:0]        num_byte;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       st_data;
  logic [31:0]       ld_data;
  logic              ld_valid;
  logic              stall;
  logic              err;
  lsu_state_e        dbg_state;

  modport master (
    output mem_read, mem_wren, num_byte, addr, st_data,
    input  ld_data, ld_valid, stall, err, dbg_state
  );

  modport slave (
    input  mem_read, mem_wren, num_byte, addr, st_data,
    output ld_data, ld_valid, stall, err, dbg_state
  );

endinterface

// File: rtl/lsu_dmem.sv
// Single-port data RAM, 32-bit words, synchronous read, per-byte write enables.
module lsu_dmem #(
  parameter int DEPTH_WORDS = 2048,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [3:0]       we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    if (en_i) rdata_q <= mem[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lsu_misalign_unit.sv
// Load/store unit that splits word-crossing halfword/word accesses into two
// RAM transactions and returns sign/zero-extended load data.
module lsu_misalign_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 2048,
  parameter int ADDR_W      = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  lsu_misalign_unit_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  lsu_state_e       state_q, state_d;
  logic [1:0]       off_q;
  logic [2:0]       nb_q;
  logic [IDX_W-1:0] idx1_q;
  logic [31:0]      word0_q;
  logic [31:0]      hi_data_q;
  logic [3:0]       hi_be_q;
  logic [31:0]      ld_data_q;
  logic             ld_valid_q;
  logic             err_q;

  logic [ADDR_W-1:0] addr_in;
  logic [IDX_W-1:0]  idx_in;
  logic [1:0]        off_in;
  acc_size_e         in_size;
  logic              in_cross;
  logic              st_illegal;
  logic [63:0]       st_lane;
  logic [7:0]        st_be;
  logic              unused_addr_hi;

  assign addr_in        = bus.addr;
  assign idx_in         = addr_in[IDX_W+1:2];
  assign off_in         = addr_in[1:0];
  assign unused_addr_hi = ^addr_in[ADDR_W-1:IDX_W+2];
  assign in_size        = size_of(bus.num_byte);
  assign in_cross       = crosses(in_size, off_in);
  assign st_illegal     = (bus.num_byte > 3'd4);
  assign st_lane        = {32'd0, bus.st_data} << {off_in, 3'b000};
  assign st_be          = lane_be(in_size, off_in);

  logic             mem_en;
  logic [3:0]       mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;
  logic             stall_raw;

  lsu_dmem #(.DEPTH_WORDS(DEPTH_WORDS)) u_dmem (
    .clk_i   (i_clk),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .idx_i   (mem_idx),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d   = state_q;
    mem_en    = 1'b0;
    mem_we    = 4'd0;
    mem_idx   = idx_in;
    mem_wdata = st_lane[31:0];
    stall_raw = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.mem_read && bus.mem_wren) begin
          state_d = S_IDLE;
        end else if (bus.mem_read) begin
          mem_en    = 1'b1;
          stall_raw = 1'b1;
          state_d   = S_RD_LO;
        end else if (bus.mem_wren && !st_illegal) begin
          mem_en = 1'b1;
          mem_we = st_be[3:0];
          if (in_cross) begin
            stall_raw = 1'b1;
            state_d   = S_WR_HI;
          end
        end
      end
      S_RD_LO: begin
        stall_raw = 1'b1;
        if (crosses(size_of(nb_q), off_q)) begin
          mem_en  = 1'b1;
          mem_idx = idx1_q;
          state_d = S_RD_HI;
        end else begin
          state_d = S_RESP;
        end
      end
      S_RD_HI: begin
        stall_raw = 1'b1;
        state_d   = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      S_WR_HI: begin
        mem_en    = 1'b1;
        mem_idx   = idx1_q;
        mem_we    = hi_be_q;
        mem_wdata = hi_data_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // In RD_LO the RAM output is word0; in RD_HI it is word1 and word0 is held.
  logic [31:0] lo_word;
  logic [31:0] ld_shift;
  logic [31:0] ld_ext;

  assign lo_word  = (state_q == S_RD_LO) ? mem_rdata : word0_q;
  assign ld_shift = 32'({mem_rdata, lo_word} >> {off_q, 3'b000});

  always_comb begin
    ld_ext = ld_shift;
    case (nb_q)
      NB_B:    ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      NB_BU:   ld_ext = {24'd0, ld_shift[7:0]};
      NB_H:    ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
      NB_HU:   ld_ext = {16'd0, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      off_q      <= 2'd0;
      nb_q       <= 3'd0;
      idx1_q     <= '0;
      word0_q    <= 32'd0;
      hi_data_q  <= 32'd0;
      hi_be_q    <= 4'd0;
      ld_data_q  <= 32'd0;
      ld_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE) begin
        off_q     <= off_in;
        nb_q      <= bus.num_byte;
        idx1_q    <= idx_in + 1'b1;
        hi_data_q <= st_lane[63:32];
        hi_be_q   <= st_be[7:4];
      end
      if (state_q == S_RD_LO) word0_q <= mem_rdata;
      // Result is registered on entry to RESP so ld_valid and ld_data line up there.
      ld_valid_q <= (state_d == S_RESP);
      if (state_d == S_RESP) ld_data_q <= ld_ext;
      err_q <= ((state_q == S_IDLE) && bus.mem_wren && (bus.mem_read || st_illegal)) ||
               ((state_d == S_RESP) && (nb_q > 3'd4));
    end
  end

  assign bus.stall     = stall_raw & ~i_reset;
  assign bus.ld_data   = ld_data_q;
  assign bus.ld_valid  = ld_valid_q;
  assign bus.err       = err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_lsu_misalign_unit.sv
// Bench for lsu_misalign_unit: byte-addressed reference memory, directed
// corner cases and random traffic, load results checked from a queue.
module tb_lsu_misalign_unit;
  import lsu_pkg::*;

  localparam int DEPTH  = 2048;
  localparam int NBYTES = DEPTH * 4;
  localparam int W      = 33;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lsu_misalign_unit_if #(.ADDR_W(32)) bus();

  lsu_misalign_unit #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]   ref_mem [NBYTES];
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int err_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int op_size(input logic [2:0] nb);
    if (nb <= 3'd1) return 1;
    if (nb <= 3'd3) return 2;
    return 4;
  endfunction

  function automatic bit op_crosses(input logic [2:0] nb, input logic [31:0] a);
    return (int'(a[1:0]) + op_size(nb)) > 4;
  endfunction

  function automatic int byte_index(input logic [31:0] a, input int i);
    return (int'(a & 32'(NBYTES - 1)) + i) % NBYTES;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] nb, input logic [31:0] a);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < op_size(nb); i++) v[8*i +: 8] = ref_mem[byte_index(a, i)];
    if (nb == 3'd0) v = {{24{v[7]}}, v[7:0]};
    if (nb == 3'd2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] nb, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < op_size(nb); i++) ref_mem[byte_index(a, i)] = d[8*i +: 8];
  endtask

  // Monitor: pops the expected load result whenever the DUT reports one.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst) begin
      if (bus.err) err_cnt++;
      if (bus.ld_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_ld_valid: got ld_data %h, required no pulse", bus.ld_data);
        end else begin
          e = exp_q.pop_front();
          check("ld_data", bus.ld_data, e[31:0]);
          check("ld_err", 32'(bus.err), 32'(e[32]));
        end
      end
    end
  end

  task automatic run_op(input bit rd, input bit wr, input logic [2:0] nb,
                        input logic [31:0] a, input logic [31:0] d);
    bit exp_err;
    int exp_stall;
    int stalls;
    int cyc;
    bit done;
    int err_before;
    exp_err   = (rd && wr) || ((rd || wr) && (nb > 3'd4));
    exp_stall = 0;
    if (rd && !wr) begin
      exp_q.push_back({exp_err, ref_load(nb, a)});
      exp_stall = op_crosses(nb, a) ? 3 : 2;
    end else if (wr && !rd && (nb <= 3'd4)) begin
      ref_store(nb, a, d);
      exp_stall = op_crosses(nb, a) ? 1 : 0;
    end
    err_before   = err_cnt;
    bus.mem_read = rd;
    bus.mem_wren = wr;
    bus.num_byte = nb;
    bus.addr     = a;
    bus.st_data  = d;
    stalls = 0;
    cyc    = 0;
    done   = 1'b0;
    while (!done && cyc < 16) begin
      @(negedge clk);
      if (bus.stall) stalls++;
      else begin
        done = 1'b1;
        if (rd && !wr) check("ld_valid_latency", 32'(bus.ld_valid), 32'd1);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    check("op_completed", 32'(done), 32'd1);
    check("stall_cycles", 32'(stalls), 32'(exp_stall));
    bus.mem_read = 1'b0;
    bus.mem_wren = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    check("err_pulses", 32'(err_cnt - err_before), 32'(exp_err));
  endtask

  initial begin
    bit rd;
    bit wr;
    int sel;
    bus.mem_read = 1'b1;
    bus.mem_wren = 1'b0;
    bus.num_byte = 3'd4;
    bus.addr     = 32'h0;
    bus.st_data  = 32'h0;

    // Reset with a load request pending: all outputs quiet, stall forced low.
    repeat (2) @(negedge clk);
    check("rst_ld_data", bus.ld_data, 32'd0);
    check("rst_ld_valid", 32'(bus.ld_valid), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(S_IDLE));
    bus.mem_read = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int w = 0; w < DEPTH; w++) run_op(1'b0, 1'b1, 3'd4, 32'(w * 4), $urandom());

    run_op(1'b0, 1'b1, 3'd4, 32'h100, 32'hDEADBEEF);
    run_op(1'b1, 1'b0, 3'd4, 32'h100, 32'h0);
    run_op(1'b0, 1'b1, 3'd0, 32'h103, 32'h00000080);
    run_op(1'b1, 1'b0, 3'd0, 32'h103, 32'h0);
    run_op(1'b1, 1'b0, 3'd1, 32'h103, 32'h0);
    run_op(1'b0, 1'b1, 3'd2, 32'h107, 32'h0000A55A);
    run_op(1'b1, 1'b0, 3'd3, 32'h107, 32'h0);
    run_op(1'b1, 1'b0, 3'd1, 32'h107, 32'h0);
    run_op(1'b1, 1'b0, 3'd1, 32'h108, 32'h0);
    run_op(1'b1, 1'b0, 3'd2, 32'h107, 32'h0);
    run_op(1'b0, 1'b1, 3'd4, 32'h1FFE, 32'h11223344);
    run_op(1'b1, 1'b0, 3'd4, 32'h1FFE, 32'h0);
    run_op(1'b1, 1'b0, 3'd3, 32'h0, 32'h0);
    run_op(1'b1, 1'b0, 3'd4, 32'hFFFF_E1FF, 32'h0);
    run_op(1'b0, 1'b1, 3'd6, 32'h200, 32'hCAFEF00D);
    run_op(1'b1, 1'b0, 3'd4, 32'h200, 32'h0);
    run_op(1'b1, 1'b1, 3'd4, 32'h204, 32'h12345678);
    run_op(1'b1, 1'b0, 3'd4, 32'h204, 32'h0);
    run_op(1'b1, 1'b0, 3'd7, 32'h206, 32'h0);
    run_op(1'b0, 1'b1, 3'd1, 32'h30D, 32'hFFFF_FF5C);
    run_op(1'b0, 1'b1, 3'd3, 32'h30F, 32'hABCD_1234);
    run_op(1'b1, 1'b0, 3'd4, 32'h30C, 32'h0);
    run_op(1'b1, 1'b0, 3'd4, 32'h310, 32'h0);

    // Reset while a crossing lw sits in RD_HI.
    bus.mem_read = 1'b1;
    bus.mem_wren = 1'b0;
    bus.num_byte = 3'd4;
    bus.addr     = 32'h205;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("mid_state_rd_hi", 32'(bus.dbg_state), 32'(S_RD_HI));
    rst = 1'b1;
    #1;
    check("mid_rst_ld_valid", 32'(bus.ld_valid), 32'd0);
    check("mid_rst_ld_data", bus.ld_data, 32'd0);
    check("mid_rst_stall", 32'(bus.stall), 32'd0);
    check("mid_rst_err", 32'(bus.err), 32'd0);
    check("mid_rst_state", 32'(bus.dbg_state), 32'(S_IDLE));
    bus.mem_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_op(1'b1, 1'b0, 3'd4, 32'h205, 32'h0);

    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 9);
      rd  = (sel <= 4) || (sel == 9);
      wr  = (sel >= 5);
      run_op(rd, wr, 3'($urandom_range(0, 7)), $urandom(), $urandom());
    end

    repeat (5) @(posedge clk);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
